// File: rtl/avalon_window_fetcher_pkg.sv
// Shared types and helpers for the 3x3 window fetcher: FSM encoding, tap indexing, clamping.
package avalon_window_fetcher_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_ADVANCE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam int TAP_COUNT = 9;
    localparam int TAP_W     = 4;

    localparam logic [TAP_W-1:0] TAP_FIRST  = 4'd0;
    localparam logic [TAP_W-1:0] TAP_CENTER = 4'd4;
    localparam logic [TAP_W-1:0] TAP_LAST   = 4'd8;

    // Border replication: out-of-image coordinates snap to the nearest edge.
    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational address generator: counter (X,Y) plus tap index -> clamped pixel address.
module window_addr_gen
    import avalon_window_fetcher_pkg::*;
#(
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          COORD_W   = 6,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [TAP_W-1:0]   k,
    output logic [ADDR_W-1:0]  addr
);

    always_comb begin
        int r;
        int c;
        int xx;
        int yy;
        r    = int'(k) / 3;
        c    = int'(k) % 3;
        xx   = clamp(int'(x) + c - 1, 0, IMG_W - 1);
        yy   = clamp(int'(y) + r - 1, 0, IMG_H - 1);
        addr = ADDR_W'(BASE_ADDR) + ADDR_W'(yy) * ADDR_W'(IMG_W) + ADDR_W'(xx);
    end

endmodule

// File: rtl/avalon_window_fetcher.sv
// Avalon-MM read master: fetches the 3x3 neighbourhood of each counter coordinate,
// one read at a time, and hands the packed window to the downstream stage.
module avalon_window_fetcher
    import avalon_window_fetcher_pkg::*;
#(
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          COORD_W   = 6,
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [COORD_W-1:0]            X_i,
    input  logic [COORD_W-1:0]            Y_i,
    input  logic                          finished_i,
    output logic                          inc_o,
    output logic                          clear_o,
    output logic [ADDR_W-1:0]             avm_address_o,
    output logic                          avm_read_o,
    input  logic                          avm_waitrequest_i,
    input  logic [DATA_W-1:0]             avm_readdata_i,
    input  logic                          avm_readdatavalid_i,
    output logic [TAP_COUNT*DATA_W-1:0]   win_data_o,
    output logic                          win_valid_o,
    input  logic                          win_ready_i,
    output logic                          busy_o,
    output logic                          done_o
);

    state_t                                state;
    state_t                                state_nxt;
    logic [TAP_W-1:0]                      k;
    logic [TAP_W-1:0]                      k_nxt;
    logic [TAP_COUNT-1:0][DATA_W-1:0]      taps;
    logic [ADDR_W-1:0]                     tap_addr;

    window_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .COORD_W   (COORD_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .x    (X_i),
        .y    (Y_i),
        .k    (k),
        .addr (tap_addr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            k     <= TAP_FIRST;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Only a response arriving while WAIT is active belongs to the outstanding read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            taps <= '0;
        else if (state == S_WAIT && avm_readdatavalid_i)
            taps[k] <= avm_readdata_i;
    end

    assign win_data_o = taps;

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        inc_o         = 1'b0;
        clear_o       = 1'b0;
        avm_read_o    = 1'b0;
        avm_address_o = '0;
        win_valid_o   = 1'b0;
        done_o        = 1'b0;
        busy_o        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_i)
                    state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                clear_o   = 1'b1;
                k_nxt     = TAP_FIRST;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                avm_read_o    = 1'b1;
                avm_address_o = tap_addr;
                if (!avm_waitrequest_i)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (avm_readdatavalid_i) begin
                    if (k == TAP_LAST) begin
                        state_nxt = S_PRESENT;
                    end else begin
                        k_nxt     = k + 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_PRESENT: begin
                win_valid_o = 1'b1;
                if (win_ready_i)
                    state_nxt = finished_i ? S_DONE : S_ADVANCE;
            end
            S_ADVANCE: begin
                inc_o     = 1'b1;
                k_nxt     = TAP_FIRST;
                state_nxt = S_SETTLE;
            end
            // Lets the counter's new X/Y propagate before the next address is formed.
            S_SETTLE: begin
                state_nxt = S_ISSUE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
